// File: rtl/tis_pkg.sv
// Shared encodings for the TIS node sequencer: opcodes, operand selects,
// FSM states, ALU operations and neighbour port indices.
package tis_pkg;

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_SWP = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JEZ = 4'd5;
    localparam logic [3:0] OP_JNZ = 4'd6;
    localparam logic [3:0] OP_JGZ = 4'd7;
    localparam logic [3:0] OP_JLZ = 4'd8;
    localparam logic [3:0] OP_NEG = 4'd9;
    localparam logic [3:0] OP_SAV = 4'd10;
    localparam logic [3:0] OP_NOP = 4'd11;
    localparam logic [3:0] OP_JRO = 4'd12;

    // Codes below SEL_ACC address neighbour ports directly.
    localparam logic [2:0] SEL_ACC = 3'd4;
    localparam logic [2:0] SEL_NIL = 3'd5;
    localparam logic [2:0] SEL_IMM = 3'd6;

    localparam int PORT_UP    = 0;
    localparam int PORT_RIGHT = 1;
    localparam int PORT_DOWN  = 2;
    localparam int PORT_LEFT  = 3;

    typedef enum logic [1:0] {
        ST_EXEC    = 2'd0,
        ST_RX_WAIT = 2'd1,
        ST_TX_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_NEG = 2'd2
    } alu_op_t;

endpackage

// File: rtl/tis_sat_alu.sv
// Combinational saturating add/sub/negate; computed one bit wider than the
// data path so the clamp sees the true result before truncation.
module tis_sat_alu
    import tis_pkg::*;
#(
    parameter int DATA_W  = 11,
    parameter int SAT_MAX = 999
) (
    input  alu_op_t                   op_i,
    input  logic signed [DATA_W-1:0]  a_i,
    input  logic signed [DATA_W-1:0]  b_i,
    output logic signed [DATA_W-1:0]  y_o
);

    localparam logic signed [DATA_W:0] SAT_HI = (DATA_W+1)'(SAT_MAX);
    localparam logic signed [DATA_W:0] SAT_LO = -SAT_HI;

    logic signed [DATA_W:0] a_w;
    logic signed [DATA_W:0] b_w;
    logic signed [DATA_W:0] raw_w;

    assign a_w = {a_i[DATA_W-1], a_i};
    assign b_w = {b_i[DATA_W-1], b_i};

    always_comb begin
        raw_w = a_w + b_w;
        case (op_i)
            ALU_SUB: raw_w = a_w - b_w;
            ALU_NEG: raw_w = '0 - a_w;
            default: raw_w = a_w + b_w;
        endcase
    end

    always_comb begin
        y_o = raw_w[DATA_W-1:0];
        if (raw_w > SAT_HI) begin
            y_o = SAT_HI[DATA_W-1:0];
        end else if (raw_w < SAT_LO) begin
            y_o = SAT_LO[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/tis_node_sequencer.sv
// TIS node control unit: fetch/execute sequencer with PC, ACC, BAK and a
// blocking valid/ready handshake towards the neighbour ports.
module tis_node_sequencer
    import tis_pkg::*;
#(
    parameter int DATA_W    = 11,
    parameter int PC_W      = 4,
    parameter int PROG_LEN  = 15,
    parameter int NUM_PORTS = 4,
    parameter int SAT_MAX   = 999
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [PC_W-1:0]               pc_o,
    input  logic [3:0]                    op_i,
    input  logic [2:0]                    src_i,
    input  logic [2:0]                    dst_i,
    input  logic [DATA_W-1:0]             imm_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   rx_data_i,
    input  logic [NUM_PORTS-1:0]          rx_valid_i,
    output logic [NUM_PORTS-1:0]          rx_ready_o,
    output logic [DATA_W-1:0]             tx_data_o,
    output logic [NUM_PORTS-1:0]          tx_valid_o,
    input  logic [NUM_PORTS-1:0]          tx_ready_i,
    output logic [DATA_W-1:0]             acc_o,
    output logic [DATA_W-1:0]             bak_o,
    output logic                          stall_o
);

    localparam int JW = ((DATA_W > PC_W) ? DATA_W : PC_W) + 2;
    localparam logic [PC_W-1:0]       PC_MAX   = PC_W'(PROG_LEN - 1);
    localparam logic signed [JW-1:0]  PC_MAX_S = JW'(PROG_LEN - 1);

    state_t                    state_q, state_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic signed [DATA_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0]  bak_q, bak_d;
    logic [DATA_W-1:0]         tx_data_q, tx_data_d;
    logic [NUM_PORTS-1:0]      tx_valid_q, tx_valid_d;

    logic signed [DATA_W-1:0]  rx_word [NUM_PORTS];
    logic [NUM_PORTS-1:0]      src_sel;
    logic [NUM_PORTS-1:0]      dst_sel;
    logic signed [DATA_W-1:0]  port_word;
    logic signed [DATA_W-1:0]  operand;
    logic                      src_is_port;
    logic                      dst_is_port;
    logic                      uses_src;
    logic                      operand_ok;
    logic [PC_W-1:0]           pc_inc;
    logic [PC_W-1:0]           jmp_tgt;
    logic signed [JW-1:0]      jro_sum;
    logic [PC_W-1:0]           jro_pc;
    logic                      acc_zero;
    logic                      acc_neg;
    alu_op_t                   alu_op;
    logic signed [DATA_W-1:0]  alu_y;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign rx_word[gi] = rx_data_i[gi*DATA_W +: DATA_W];
            assign src_sel[gi] = (src_i == 3'(gi));
            assign dst_sel[gi] = (dst_i == 3'(gi));
        end
    endgenerate

    always_comb begin
        port_word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (src_sel[p]) begin
                port_word = rx_word[p];
            end
        end
    end

    assign src_is_port = |src_sel;
    assign dst_is_port = |dst_sel;
    assign uses_src    = (op_i == OP_MOV) || (op_i == OP_ADD) ||
                         (op_i == OP_SUB) || (op_i == OP_JRO);
    assign operand_ok  = !(uses_src && src_is_port) || (|(src_sel & rx_valid_i));

    always_comb begin
        operand = '0;
        if (src_is_port) begin
            operand = port_word;
        end else if (src_i == SEL_ACC) begin
            operand = acc_q;
        end else if (src_i == SEL_IMM) begin
            operand = imm_i;
        end
    end

    assign pc_inc   = (pc_q == PC_MAX) ? '0 : pc_q + 1'b1;
    assign jmp_tgt  = (imm_i[PC_W-1:0] > PC_MAX) ? '0 : imm_i[PC_W-1:0];
    assign acc_zero = (acc_q == '0);
    assign acc_neg  = acc_q[DATA_W-1];

    // Relative jump is evaluated wide and signed, then clamped into the program.
    assign jro_sum = JW'($signed({1'b0, pc_q})) + JW'(operand);
    always_comb begin
        jro_pc = jro_sum[PC_W-1:0];
        if (jro_sum < 0) begin
            jro_pc = '0;
        end else if (jro_sum > PC_MAX_S) begin
            jro_pc = PC_MAX;
        end
    end

    always_comb begin
        alu_op = ALU_ADD;
        if (op_i == OP_SUB) begin
            alu_op = ALU_SUB;
        end else if (op_i == OP_NEG) begin
            alu_op = ALU_NEG;
        end
    end

    tis_sat_alu #(
        .DATA_W  (DATA_W),
        .SAT_MAX (SAT_MAX)
    ) u_alu (
        .op_i (alu_op),
        .a_i  (acc_q),
        .b_i  (operand),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        bak_d      = bak_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rx_ready_o = '0;
        case (state_q)
            ST_EXEC, ST_RX_WAIT: begin
                if (uses_src && src_is_port) begin
                    rx_ready_o = src_sel;
                end
                if (!operand_ok) begin
                    state_d = ST_RX_WAIT;
                end else begin
                    state_d = ST_EXEC;
                    pc_d    = pc_inc;
                    case (op_i)
                        OP_MOV: begin
                            if (dst_is_port) begin
                                tx_data_d  = operand;
                                tx_valid_d = dst_sel;
                                pc_d       = pc_q;
                                state_d    = ST_TX_WAIT;
                            end else if (dst_i == SEL_ACC) begin
                                acc_d = operand;
                            end
                        end
                        OP_SWP: begin
                            acc_d = bak_q;
                            bak_d = acc_q;
                        end
                        OP_SUB, OP_ADD, OP_NEG: acc_d = alu_y;
                        OP_SAV: bak_d = acc_q;
                        OP_JMP: pc_d = jmp_tgt;
                        OP_JEZ: if (acc_zero) pc_d = jmp_tgt;
                        OP_JNZ: if (!acc_zero) pc_d = jmp_tgt;
                        OP_JGZ: if (!acc_zero && !acc_neg) pc_d = jmp_tgt;
                        OP_JLZ: if (acc_neg) pc_d = jmp_tgt;
                        OP_JRO: pc_d = jro_pc;
                        default: ;
                    endcase
                end
            end
            ST_TX_WAIT: begin
                if (|(tx_valid_q & tx_ready_i)) begin
                    tx_valid_d = '0;
                    pc_d       = pc_inc;
                    state_d    = ST_EXEC;
                end
            end
            default: state_d = ST_EXEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EXEC;
            pc_q       <= '0;
            acc_q      <= '0;
            bak_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            bak_q      <= bak_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign pc_o       = pc_q;
    assign acc_o      = acc_q;
    assign bak_o      = bak_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign stall_o    = (state_q != ST_EXEC);

endmodule

// File: tb/tb_tis_node_sequencer.sv
// Directed bench for tis_node_sequencer; expectations are queued when an
// instruction is driven and compared once the clock edge has executed it.
module tb_tis_node_sequencer;
    import tis_pkg::*;

    localparam int DATA_W = 11;
    localparam int PC_W   = 4;
    localparam int NP     = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [PC_W-1:0]        pc_o;
    logic [3:0]             op_i;
    logic [2:0]             src_i;
    logic [2:0]             dst_i;
    logic [DATA_W-1:0]      imm_i;
    logic [NP*DATA_W-1:0]   rx_data_i;
    logic [NP-1:0]          rx_valid_i;
    logic [NP-1:0]          rx_ready_o;
    logic [DATA_W-1:0]      tx_data_o;
    logic [NP-1:0]          tx_valid_o;
    logic [NP-1:0]          tx_ready_i;
    logic [DATA_W-1:0]      acc_o;
    logic [DATA_W-1:0]      bak_o;
    logic                   stall_o;

    typedef struct {
        string       name;
        string       sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tis_node_sequencer #(
        .DATA_W    (DATA_W),
        .PC_W      (PC_W),
        .PROG_LEN  (15),
        .NUM_PORTS (NP),
        .SAT_MAX   (999)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_o       (pc_o),
        .op_i       (op_i),
        .src_i      (src_i),
        .dst_i      (dst_i),
        .imm_i      (imm_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .acc_o      (acc_o),
        .bak_o      (bak_o),
        .stall_o    (stall_o)
    );

    function automatic logic [31:0] get_obs(input string sig);
        if (sig == "pc")    return 32'(pc_o);
        if (sig == "acc")   return {{(32-DATA_W){acc_o[DATA_W-1]}}, acc_o};
        if (sig == "bak")   return {{(32-DATA_W){bak_o[DATA_W-1]}}, bak_o};
        if (sig == "txd")   return {{(32-DATA_W){tx_data_o[DATA_W-1]}}, tx_data_o};
        if (sig == "txv")   return 32'(tx_valid_o);
        if (sig == "rxr")   return 32'(rx_ready_o);
        if (sig == "stall") return 32'(stall_o);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic void expect_val(input string name, input string sig, input int val);
        exp_t e;
        e.name = {name, ".", sig};
        e.sig  = sig;
        e.val  = 32'(val);
        sb.push_back(e);
    endfunction

    task automatic check_pending();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_obs(e.sig);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.name, $signed(obs), $signed(e.val));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_pending();
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] src,
                         input logic [2:0] dst, input int imm);
        op_i  = op;
        src_i = src;
        dst_i = dst;
        imm_i = DATA_W'(imm);
    endtask

    task automatic exec(input string name, input logic [3:0] op, input logic [2:0] src,
                        input logic [2:0] dst, input int imm, input int pc_e, input int acc_e);
        drive(op, src, dst, imm);
        expect_val(name, "pc", pc_e);
        expect_val(name, "acc", acc_e);
        expect_val(name, "stall", 0);
        tick();
        $display("step %-10s op=%0d src=%0d dst=%0d imm=%0d -> pc=%0d acc=%0d",
                 name, op, src, dst, imm, pc_o, $signed(acc_o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        rx_data_i  = '0;
        rx_valid_i = '0;
        tx_ready_i = '0;
        drive(OP_NOP, SEL_NIL, SEL_NIL, 0);
        repeat (2) @(negedge clk);
        expect_val("reset", "pc", 0);
        expect_val("reset", "acc", 0);
        expect_val("reset", "bak", 0);
        expect_val("reset", "txd", 0);
        expect_val("reset", "txv", 0);
        expect_val("reset", "rxr", 0);
        expect_val("reset", "stall", 0);
        check_pending();
        rst = 1'b0;

        // Saturating arithmetic
        exec("t2_ld990",  OP_MOV, SEL_IMM, SEL_ACC, 990,  1, 990);
        exec("t2_addsat", OP_ADD, SEL_IMM, SEL_NIL, 20,   2, 999);
        exec("t2_ldm990", OP_MOV, SEL_IMM, SEL_ACC, -990, 3, -990);
        exec("t2_subsat", OP_SUB, SEL_IMM, SEL_NIL, 20,   4, -999);
        exec("t2_ld999",  OP_MOV, SEL_IMM, SEL_ACC, 999,  5, 999);
        exec("t2_neg",    OP_NEG, SEL_NIL, SEL_NIL, 0,    6, -999);

        // SAV / SWP
        expect_val("t6_sav", "bak", -999);
        exec("t6_sav",    OP_SAV, SEL_NIL, SEL_NIL, 0,    7, -999);
        exec("t6_ld5",    OP_MOV, SEL_IMM, SEL_ACC, 5,    8, 5);
        expect_val("t6_swp", "bak", 5);
        exec("t6_swp",    OP_SWP, SEL_NIL, SEL_NIL, 0,    9, -999);

        // Conditional and absolute jumps
        exec("t5_ld0",    OP_MOV, SEL_IMM, SEL_ACC, 0,    10, 0);
        exec("t5_jez",    OP_JEZ, SEL_NIL, SEL_NIL, 9,    9,  0);
        exec("t5_jnz",    OP_JNZ, SEL_NIL, SEL_NIL, 9,    10, 0);
        exec("t5_ldm1",   OP_MOV, SEL_IMM, SEL_ACC, -1,   11, -1);
        exec("t5_jlz",    OP_JLZ, SEL_NIL, SEL_NIL, 3,    3,  -1);
        exec("t5_jgz",    OP_JGZ, SEL_NIL, SEL_NIL, 7,    4,  -1);
        exec("t5_jmp15",  OP_JMP, SEL_NIL, SEL_NIL, 15,   0,  -1);

        // Relative jumps, wrap, unused opcode
        exec("t6_jmp2",   OP_JMP, SEL_NIL, SEL_NIL, 2,    2,  -1);
        exec("t6_jrom5",  OP_JRO, SEL_IMM, SEL_NIL, -5,   0,  -1);
        exec("t6_jmp12",  OP_JMP, SEL_NIL, SEL_NIL, 12,   12, -1);
        exec("t6_jro10",  OP_JRO, SEL_IMM, SEL_NIL, 10,   14, -1);
        exec("t6_wrap",   OP_NOP, SEL_NIL, SEL_NIL, 0,    0,  -1);
        exec("t6_op14",   4'd14,  SEL_IMM, SEL_ACC, 77,   1,  -1);
        exec("t6_add3",   OP_ADD, SEL_IMM, SEL_NIL, 3,    2,  2);

        // Blocking read from UP
        drive(OP_MOV, 3'(PORT_UP), SEL_ACC, 0);
        #1;
        expect_val("t3_rdy", "rxr", 1);
        check_pending();
        for (int i = 0; i < 3; i++) begin
            expect_val("t3_wait", "stall", 1);
            expect_val("t3_wait", "pc", 2);
            expect_val("t3_wait", "acc", 2);
            tick();
            $display("step t3_wait%0d stall=%0b pc=%0d", i, stall_o, pc_o);
        end
        rx_data_i[PORT_UP*DATA_W +: DATA_W] = DATA_W'(7);
        rx_valid_i = 4'b0001;
        expect_val("t3_done", "stall", 0);
        expect_val("t3_done", "acc", 7);
        expect_val("t3_done", "pc", 3);
        tick();
        $display("step t3_done acc=%0d pc=%0d", $signed(acc_o), pc_o);
        rx_valid_i = '0;

        // Port to port: LEFT -> DOWN
        drive(OP_MOV, 3'(PORT_LEFT), 3'(PORT_DOWN), 0);
        rx_data_i[PORT_LEFT*DATA_W +: DATA_W] = DATA_W'(5);
        rx_valid_i = 4'b1000;
        expect_val("t4_rx", "txv", 4);
        expect_val("t4_rx", "txd", 5);
        expect_val("t4_rx", "stall", 1);
        expect_val("t4_rx", "pc", 3);
        tick();
        $display("step t4_rx txv=%b txd=%0d", tx_valid_o, tx_data_o);
        rx_valid_i = '0;
        #1;
        expect_val("t4_noread", "rxr", 0);
        check_pending();
        expect_val("t4_hold", "txv", 4);
        expect_val("t4_hold", "txd", 5);
        expect_val("t4_hold", "stall", 1);
        tick();
        $display("step t4_hold txv=%b txd=%0d", tx_valid_o, tx_data_o);
        tx_ready_i = 4'b0100;
        expect_val("t4_acc", "txv", 0);
        expect_val("t4_acc", "pc", 4);
        expect_val("t4_acc", "stall", 0);
        tick();
        $display("step t4_acc txv=%b pc=%0d", tx_valid_o, pc_o);
        tx_ready_i = '0;

        // Reset while a write to RIGHT is pending
        drive(OP_MOV, SEL_ACC, 3'(PORT_RIGHT), 0);
        expect_val("t1_tx", "txv", 2);
        expect_val("t1_tx", "txd", 7);
        expect_val("t1_tx", "pc", 4);
        tick();
        $display("step t1_tx txv=%b txd=%0d", tx_valid_o, tx_data_o);
        expect_val("t1_hold", "txv", 2);
        expect_val("t1_hold", "stall", 1);
        tick();
        $display("step t1_hold txv=%b", tx_valid_o);
        rst = 1'b1;
        drive(OP_NOP, SEL_NIL, SEL_NIL, 0);
        expect_val("t1_rst", "txv", 0);
        expect_val("t1_rst", "pc", 0);
        expect_val("t1_rst", "acc", 0);
        expect_val("t1_rst", "bak", 0);
        expect_val("t1_rst", "stall", 0);
        tick();
        $display("step t1_rst txv=%b pc=%0d acc=%0d", tx_valid_o, pc_o, $signed(acc_o));
        rst = 1'b0;
        exec("post_rst",  OP_MOV, SEL_IMM, SEL_ACC, 1,    1,  1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
